// File: rtl/gen3_pi_pkg.sv
// -----------------------------------------------------------------------------
// gen3_pi_pkg
// Shared definitions for the multi-byte Gen3 packet identifier: per-byte
// one-hot type codes, the framing state encoding and the framing tokens
// recognised in the descrambled 128b/130b data stream.
// -----------------------------------------------------------------------------
package gen3_pi_pkg;

   // One-hot per-byte type codes presented on type_out.
   localparam logic [5:0] TYPE_NV        = 6'b000000;
   localparam logic [5:0] TYPE_DATA      = 6'b100000;
   localparam logic [5:0] TYPE_TLPSTART  = 6'b010000;
   localparam logic [5:0] TYPE_TLPEND    = 6'b001000;
   localparam logic [5:0] TYPE_DLLPEND   = 6'b000100;
   localparam logic [5:0] TYPE_DLLPSTART = 6'b000010;
   localparam logic [5:0] TYPE_TLPEDB    = 6'b000001;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE     = 3'd0,
      ST_SDP1     = 3'd1,
      ST_STP1     = 3'd2,
      ST_STP2     = 3'd3,
      ST_STP3     = 3'd4,
      ST_SDP_BODY = 3'd5,
      ST_TLP_BODY = 3'd6
   } state_e;

   // Framing tokens.
   localparam logic [7:0] TOK_SDP0    = 8'hF0;  // first SDP byte
   localparam logic [7:0] TOK_SDP1    = 8'h53;  // second SDP byte
   localparam logic [3:0] TOK_STP_NIB = 4'hF;   // STP marker in byte[3:0]
   localparam logic [7:0] TOK_EDB     = 8'hC0;  // end-bad marker
   localparam logic [7:0] TOK_IDL     = 8'h00;  // logical idle filler

   localparam logic [1:0] SYNC_DATA   = 2'b10;  // data-block sync header

endpackage

// File: rtl/gen3_byte_step.sv
// -----------------------------------------------------------------------------
// gen3_byte_step
// Purely combinational single-byte framing step. Given the framing state,
// byte counter and length limit ahead of one byte, it returns the state,
// counter and limit after that byte, the byte's one-hot type and an error
// flag. The top chains LANES copies of this to walk one word in lane order.
//
// Ports:
//   state_i / state_o  framing state before / after the byte
//   count_i / count_o  body byte counter before / after the byte
//   limit_i / limit_o  body length limit before / after the byte
//   byte_i             the payload byte
//   type_o             one-hot type of this byte
//   err_o              framing violation detected on this byte
// -----------------------------------------------------------------------------
module gen3_byte_step
   import gen3_pi_pkg::*;
#(
   parameter int CNT_W       = 12,
   parameter int DLLP_LEN    = 8,
   parameter int MAX_TLP_LEN = 1024
) (
   input  logic [STATE_W-1:0] state_i,
   input  logic [CNT_W-1:0]   count_i,
   input  logic [CNT_W-1:0]   limit_i,
   input  logic [7:0]         byte_i,
   output logic [STATE_W-1:0] state_o,
   output logic [CNT_W-1:0]   count_o,
   output logic [CNT_W-1:0]   limit_o,
   output logic [5:0]         type_o,
   output logic               err_o
);

   state_e           cur;
   state_e           nxt;
   logic [CNT_W-1:0] limit_stp;

   assign cur = state_e'(state_i);

   // Second STP byte supplies limit[11:4]; limit[3:0] came from the first.
   assign limit_stp = CNT_W'({byte_i, limit_i[3:0]});

   always_comb begin
      // NOTE: every output gets a default before the case so no path can
      // leave a value unassigned and infer a latch.
      nxt     = cur;
      count_o = count_i;
      limit_o = limit_i;
      type_o  = TYPE_NV;
      err_o   = 1'b0;

      case (cur)
         ST_IDLE: begin
            if (byte_i == TOK_SDP0) begin
               nxt = ST_SDP1;
            end else if (byte_i[3:0] == TOK_STP_NIB) begin
               nxt          = ST_STP1;
               limit_o[3:0] = byte_i[7:4];
            end else if (byte_i != TOK_IDL) begin
               err_o = 1'b1;
            end
         end

         ST_SDP1: begin
            if (byte_i == TOK_SDP1) begin
               nxt     = ST_SDP_BODY;
               type_o  = TYPE_DLLPSTART;
               count_o = '0;
               limit_o = CNT_W'(DLLP_LEN);
            end else begin
               nxt   = ST_IDLE;
               err_o = 1'b1;
            end
         end

         ST_STP1: begin
            if ((limit_stp > CNT_W'(MAX_TLP_LEN)) || (limit_stp == '0)) begin
               nxt     = ST_IDLE;
               limit_o = '0;
               err_o   = 1'b1;
            end else begin
               nxt     = ST_STP2;
               limit_o = limit_stp;
            end
         end

         ST_STP2: nxt = ST_STP3;

         ST_STP3: begin
            nxt     = ST_TLP_BODY;
            type_o  = TYPE_TLPSTART;
            count_o = '0;
         end

         ST_TLP_BODY, ST_SDP_BODY: begin
            if (count_i < limit_i) begin
               type_o  = TYPE_DATA;
               count_o = count_i + CNT_W'(1);
            end else begin
               nxt     = ST_IDLE;
               count_o = '0;
               limit_o = '0;
               if (cur == ST_SDP_BODY) begin
                  type_o = TYPE_DLLPEND;
               end else if (byte_i == TOK_EDB) begin
                  type_o = TYPE_TLPEDB;
               end else begin
                  type_o = TYPE_TLPEND;
               end
            end
         end

         default: nxt = ST_IDLE;
      endcase
   end

   assign state_o = nxt;

endmodule

// File: rtl/gen3_packet_identifier_mb.sv
// -----------------------------------------------------------------------------
// gen3_packet_identifier_mb
// Classifies LANES descrambled Gen3 bytes per cycle into TLP/DLLP framing
// types. Framing state is held internally and carried lane-to-lane through a
// chain of gen3_byte_step instances; all outputs are registered.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   data_in       LANES payload bytes, lane 0 = [7:0] is earliest
//   valid         data_in qualifier
//   sync_header   2'b10 data block, anything else is treated as ordered set
//   type_out      per-lane one-hot byte type, lane i = [6i+5:6i]
//   type_valid    type_out qualifier (valid delayed one cycle)
//   framing_err   one-cycle pulse on any framing violation in the word
//   in_packet     registered state is not IDLE
// -----------------------------------------------------------------------------
module gen3_packet_identifier_mb
   import gen3_pi_pkg::*;
#(
   parameter int LANES       = 4,
   parameter int DLLP_LEN    = 8,
   parameter int MAX_TLP_LEN = 1024,
   parameter int CNT_W       = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [8*LANES-1:0] data_in,
   input  logic               valid,
   input  logic [1:0]         sync_header,
   output logic [6*LANES-1:0] type_out,
   output logic               type_valid,
   output logic               framing_err,
   output logic               in_packet
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   limit_q, limit_d;
   logic [6*LANES-1:0] type_q, type_d;
   logic               type_valid_q;
   logic               err_q, err_d;
   logic               in_packet_q;

   logic [6*LANES-1:0] lane_type;
   logic [LANES-1:0]   lane_err;

   // Lane g starts from the state left by lane g-1; lane 0 from the registers.
   for (genvar g = 0; g < LANES; g++) begin : gen_lane
      logic [STATE_W-1:0] st_in, st_out;
      logic [CNT_W-1:0]   cnt_in, cnt_out;
      logic [CNT_W-1:0]   lim_in, lim_out;

      if (g == 0) begin : gen_first
         assign st_in  = state_q;
         assign cnt_in = count_q;
         assign lim_in = limit_q;
      end else begin : gen_next
         assign st_in  = gen_lane[g-1].st_out;
         assign cnt_in = gen_lane[g-1].cnt_out;
         assign lim_in = gen_lane[g-1].lim_out;
      end

      gen3_byte_step #(
         .CNT_W       (CNT_W),
         .DLLP_LEN    (DLLP_LEN),
         .MAX_TLP_LEN (MAX_TLP_LEN)
      ) u_step (
         .state_i (st_in),
         .count_i (cnt_in),
         .limit_i (lim_in),
         .byte_i  (data_in[8*g +: 8]),
         .state_o (st_out),
         .count_o (cnt_out),
         .limit_o (lim_out),
         .type_o  (lane_type[6*g +: 6]),
         .err_o   (lane_err[g])
      );
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      limit_d = limit_q;
      type_d  = '0;
      err_d   = 1'b0;

      if (valid) begin
         if (sync_header != SYNC_DATA) begin
            // An ordered set inside a packet truncates it; in IDLE it is benign.
            if (state_q != ST_IDLE) begin
               state_d = ST_IDLE;
               count_d = '0;
               limit_d = '0;
               err_d   = 1'b1;
            end
         end else begin
            state_d = state_e'(gen_lane[LANES-1].st_out);
            count_d = gen_lane[LANES-1].cnt_out;
            limit_d = gen_lane[LANES-1].lim_out;
            type_d  = lane_type;
            err_d   = |lane_err;
         end
      end
   end

   // NOTE: the reset is asynchronous, so it appears in the sensitivity list
   // and clears outputs immediately, even between clock edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         limit_q      <= '0;
         type_q       <= '0;
         type_valid_q <= 1'b0;
         err_q        <= 1'b0;
         in_packet_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q      <= state_d;
         count_q      <= count_d;
         limit_q      <= limit_d;
         type_q       <= type_d;
         type_valid_q <= valid;
         err_q        <= err_d;
         in_packet_q  <= (state_d != ST_IDLE);
      end
   end

   assign type_out    = type_q;
   assign type_valid  = type_valid_q;
   assign framing_err = err_q;
   assign in_packet   = in_packet_q;

endmodule

// File: doc/gen3_packet_identifier_mb.md
Name: gen3_packet_identifier_mb

Overview:
Multi-byte, registered successor to the Gen3 per-byte checker. Classifies LANES bytes per cycle of a Gen3 128b/130b data stream into TLP/DLLP framing types, and holds framing state internally instead of looping it back through ports. Adds sync-header gating, framing-error detection and a TLP length ceiling. It sits between the descrambler/block aligner and the TLP/DLLP extraction logic.

Parameters:
LANES, 4, bytes processed per cycle; byte 0 = data_in[7:0] is earliest in time.
DLLP_LEN, 8, fixed DLLP body byte limit after the SDP token.
MAX_TLP_LEN, 1024, largest legal STP length field; larger values raise a framing error.
CNT_W, 12, width of the byte counter and limit registers.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
data_in  in  8*LANES  descrambled payload bytes
valid  in  1  data_in qualifier
sync_header  in  2  current block's sync header: 2'b10 = data block, 2'b01 = ordered set
type_out  out  6*LANES  per-byte one-hot type; lane i = [6i+5:6i]
type_valid  out  1  type_out qualifier
framing_err  out  1  one-cycle pulse on any framing violation
in_packet  out  1  high while the registered state is inside a TLP or DLLP

Behaviour:
- Type codes: data 100000, tlpstart 010000, tlpend 001000, dllpend 000100, dllpstart 000010, tlpedb 000001, not_valid 000000.
- States: IDLE, SDP1, STP1, STP2, STP3, SDP_BODY, TLP_BODY. Registers are state, count[CNT_W], limit[CNT_W].
- Per byte, applied in lane order 0..LANES-1, with each lane using the previous lane's result:
  - IDLE, byte 0xF0 -> SDP1, type not_valid.
  - IDLE, byte[3:0] == 4'hF -> STP1, limit[3:0] = byte[7:4], type not_valid.
  - IDLE, byte 0x00 -> stay in IDLE, type not_valid.
  - IDLE, any other byte -> framing_err, stay in IDLE.
  - SDP1, byte 0x53 -> SDP_BODY, type dllpstart, count = 0, limit = DLLP_LEN.
  - SDP1, any other byte -> framing_err, go to IDLE, type not_valid.
  - STP1 -> STP2, limit[11:4] = byte. If the resulting limit > MAX_TLP_LEN or limit == 0 -> framing_err, go to IDLE, clear limit.
  - STP2 -> STP3, type not_valid.
  - STP3 -> TLP_BODY, type tlpstart, count = 0.
  - TLP_BODY, count < limit -> type data, count += 1.
  - TLP_BODY, count == limit -> type tlpedb if byte == 0xC0, else tlpend. Go to IDLE, clear count and limit.
  - SDP_BODY -> same count rule as TLP_BODY; the terminating byte is dllpend.
- An end byte and a new token can occur in the same cycle, in later lanes, and both are recognised.
- Latency: type_out, type_valid, framing_err and in_packet are registered, one cycle after the input. type_valid is valid delayed by one cycle.
- When valid = 0: state is held, type_valid = 0, type_out = 0, no error.
- When valid = 1 and sync_header != 2'b10:
  - All lanes are not_valid.
  - If state != IDLE -> framing_err, abort to IDLE and clear count and limit.
  - If state == IDLE -> stay in IDLE, no error.
- framing_err is a single pulse per cycle, regardless of how many lanes erred. After an error the remaining lanes continue from IDLE.
- Reset (async, any time, including mid-packet): state = IDLE, count = limit = 0, all outputs 0.
- Arithmetic: the count increment never wraps, because limit ≤ MAX_TLP_LEN < 2^CNT_W. Widths are unsigned CNT_W.

Decomposition:
- Package gen3_pi_pkg: type-code localparams, state enum, token constants (0xF0, 0x53, 4'hF, 0xC0).
- One combinational sub-module, gen3_byte_step. It takes state/count/limit plus one byte and returns next state/count/limit, the byte type and an error flag.
- The top instantiates gen3_byte_step LANES times in a generate chain and owns all registers.

Test Plan:
- SDP: bytes F0 53 then 8 data bytes then 1 end byte (LANES = 4) -> types dllpstart, 8×data, dllpend; no error; in_packet drops after the end byte.
- STP with byte0 = 0x3F, byte1 = 0x00 (limit = 3): bytes 3F 00 xx xx, d d d, E -> nv nv nv tlpstart, data×3, tlpend. Repeat with the final byte = 0xC0 -> tlpedb.
- Back-to-back: a DLLP end byte in lane 1 with F0 53 in lanes 2..3 of the same word -> dllpend, dllpstart in the same cycle; no error.
- Errors:
  - F0 followed by 0x12 -> framing_err pulse, state IDLE.
  - STP whose length field exceeds MAX_TLP_LEN -> framing_err, no tlpstart.
  - Stray byte 0x5A in IDLE -> framing_err.
- sync_header = 01 mid-TLP -> framing_err, all lanes not_valid; the next STP is parsed normally. valid = 0 gaps mid-packet -> count resumes unchanged.
- Assert rst mid-TLP between clock edges -> outputs and in_packet go to 0 immediately; the first post-reset F0 53 yields dllpstart.
